// File: rtl/seg_scan_ctrl.sv
// Scan controller for the 8-digit seven-segment display.
// Walks a 3-to-8 digit decoder through ON/GAP slots and serves a framed shadow-load handshake.
module seg_scan_ctrl #(
    parameter int unsigned DIV = 4,
    parameter int unsigned GAP = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        load,
    input  logic [31:0] data_in,
    input  logic [7:0]  blank,
    output logic        ack,
    output logic [2:0]  x,
    output logic [2:0]  g,
    output logic [3:0]  hex,
    output logic        frame_done
);

    localparam int unsigned CNT_MAX = (DIV > GAP) ? DIV : GAP;
    localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP - 1);
    localparam logic [2:0] G_ON  = 3'b100;
    localparam logic [2:0] G_OFF = 3'b000;

    typedef enum logic [1:0] {S_IDLE, S_ON, S_GAP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [31:0]   shadow;

    logic       frame_end_c;
    logic       accept_c;
    logic [2:0] x_inc_c;

    // A request is only taken while idle or on the edge that closes a full frame,
    // so the shadow never tears mid-scan.
    assign x_inc_c     = x + 3'd1;
    assign frame_end_c = (state == S_GAP) && (cnt == GAP_LAST) && (x == 3'd7) && en;
    assign accept_c    = load && !ack && ((state == S_IDLE) || frame_end_c);

    assign hex = shadow[{x, 2'b00} +: 4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            x          <= 3'd0;
            g          <= G_OFF;
            cnt        <= '0;
            shadow     <= '0;
            ack        <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            ack        <= accept_c;
            frame_done <= 1'b0;
            if (accept_c) begin
                shadow <= data_in;
            end

            case (state)
                S_IDLE: begin
                    x   <= 3'd0;
                    g   <= G_OFF;
                    cnt <= '0;
                    if (en) begin
                        state <= S_ON;
                        g     <= blank[0] ? G_OFF : G_ON;
                    end
                end
                S_ON: begin
                    if (!en) begin
                        state <= S_IDLE;
                        x     <= 3'd0;
                        g     <= G_OFF;
                        cnt   <= '0;
                    end else if (cnt == DIV_LAST) begin
                        state <= S_GAP;
                        cnt   <= '0;
                        g     <= G_OFF;
                    end else begin
                        cnt <= cnt + CW'(1);
                        g   <= blank[x] ? G_OFF : G_ON;
                    end
                end
                S_GAP: begin
                    if (!en) begin
                        state <= S_IDLE;
                        x     <= 3'd0;
                        g     <= G_OFF;
                        cnt   <= '0;
                    end else if (cnt == GAP_LAST) begin
                        // Digit index only moves here, while the decoder is dark.
                        state      <= S_ON;
                        cnt        <= '0;
                        x          <= x_inc_c;
                        g          <= blank[x_inc_c] ? G_OFF : G_ON;
                        frame_done <= (x == 3'd7);
                    end else begin
                        cnt <= cnt + CW'(1);
                        g   <= G_OFF;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    x     <= 3'd0;
                    g     <= G_OFF;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: expected output events are queued by the stimulus
// and popped by per-instance monitors whenever x, g, ack or frame_done moves.
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        en0 = 1'b0, load0 = 1'b0;
    logic [31:0] data0 = '0;
    logic [7:0]  blank0 = '0;
    logic        ack0, fd0;
    logic [2:0]  x0, g0;
    logic [3:0]  hex0;

    logic        en1 = 1'b0, load1 = 1'b0;
    logic [31:0] data1 = '0;
    logic [7:0]  blank1 = '0;
    logic        ack1, fd1;
    logic [2:0]  x1, g1;
    logic [3:0]  hex1;

    seg_scan_ctrl #(.DIV(4), .GAP(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .en(en0), .load(load0), .data_in(data0),
        .blank(blank0), .ack(ack0), .x(x0), .g(g0), .hex(hex0), .frame_done(fd0)
    );

    seg_scan_ctrl #(.DIV(2), .GAP(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .en(en1), .load(load1), .data_in(data1),
        .blank(blank1), .ack(ack1), .x(x1), .g(g1), .hex(hex1), .frame_done(fd1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;
    localparam int NONE = 1 << 30;

    typedef struct {
        int         cyc;
        logic [2:0] x;
        logic [2:0] g;
        logic [3:0] hex;
        logic       ack;
        logic       fd;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    task automatic push_exp(input int inst, input int c, input logic [2:0] ex, input logic [2:0] eg,
                            input logic [3:0] eh, input logic ea, input logic ef);
        exp_t e;
        e.cyc = c; e.x = ex; e.g = eg; e.hex = eh; e.ack = ea; e.fd = ef;
        if (inst == 0) q0.push_back(e);
        else           q1.push_back(e);
    endtask

    // Expected events of one frame starting at cycle base; events at or after stop are dropped.
    task automatic exp_frame(input int inst, input int base, input int div, input int gap,
                             input logic [7:0] blk, input logic [31:0] sh, input bit from_idle,
                             input bit fd, input bit ak, input int stop);
        for (int d = 0; d < 8; d++) begin
            int         t_on;
            int         t_off;
            logic [3:0] nib;
            bit         on_evt;
            t_on   = base + d * (div + gap);
            t_off  = t_on + div;
            nib    = sh[4*d +: 4];
            on_evt = (d != 0) || !from_idle || !blk[d] || ak || fd;
            if (on_evt && t_on < stop)
                push_exp(inst, t_on, 3'(d), blk[d] ? 3'b000 : 3'b100, nib, (d == 0) && ak, (d == 0) && fd);
            if (!blk[d] && t_off < stop)
                push_exp(inst, t_off, 3'(d), 3'b000, nib, 1'b0, 1'b0);
        end
    endtask

    task automatic mon_step(input int inst, input int c, input logic [2:0] ox, input logic [2:0] og,
                            input logic [3:0] oh, input logic oa, input logic ofd);
        exp_t e;
        bit   have;
        have = 1'b0;
        if (inst == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
        if (inst == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
        n_vec++;
        if (!have) begin
            n_err++;
            $display("FAIL unexpected_event dut%0d cyc=%0d got x=%0d g=%b hex=%h ack=%b fd=%b, expected none",
                     inst, c, ox, og, oh, oa, ofd);
        end else if (c != e.cyc || ox != e.x || og != e.g || oh != e.hex || oa != e.ack || ofd != e.fd) begin
            n_err++;
            $display("FAIL event dut%0d got cyc=%0d x=%0d g=%b hex=%h ack=%b fd=%b, expected cyc=%0d x=%0d g=%b hex=%h ack=%b fd=%b",
                     inst, c, ox, og, oh, oa, ofd, e.cyc, e.x, e.g, e.hex, e.ack, e.fd);
        end
    endtask

    logic [2:0] px0 = '0, pg0 = '0, px1 = '0, pg1 = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            px0 <= '0; pg0 <= '0;
        end else begin
            if (ack0 || fd0 || x0 != px0 || g0 != pg0) mon_step(0, cyc, x0, g0, hex0, ack0, fd0);
            px0 <= x0; pg0 <= g0;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            px1 <= '0; pg1 <= '0;
        end else begin
            if (ack1 || fd1 || x1 != px1 || g1 != pg1) mon_step(1, cyc, x1, g1, hex1, ack1, fd1);
            px1 <= x1; pg1 <= g1;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_vec++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s got %h expected %h", name, got, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int n);
        while (cyc < n) tick();
    endtask

    int e, e2, e3;

    initial begin
        #1;
        check("rst_x",   32'(x0),   32'd0);
        check("rst_g",   32'(g0),   32'd0);
        check("rst_hex", 32'(hex0), 32'd0);
        check("rst_ack", 32'(ack0), 32'd0);
        check("rst_fd",  32'(fd0),  32'd0);
        check("rst_g1",  32'(g1),   32'd0);

        goto(3);
        rst_n = 1'b1;

        // Idle load: ack one cycle after load is sampled
        goto(5);
        load0 = 1'b1; data0 = 32'h76543210;
        push_exp(0, cyc + 1, 3'd0, 3'b000, 4'h0, 1'b1, 1'b0);
        tick();
        load0 = 1'b0;

        // Scan five frames: plain, plain, mid-frame load, blanked, then en drop at digit 5
        goto(8);
        en0 = 1'b1;
        e = cyc + 1;
        exp_frame(0, e,       4, 1, 8'h00, 32'h76543210, 1'b1, 1'b0, 1'b0, NONE);
        exp_frame(0, e + 40,  4, 1, 8'h00, 32'h76543210, 1'b0, 1'b1, 1'b0, NONE);
        exp_frame(0, e + 80,  4, 1, 8'h00, 32'hFEDCBA98, 1'b0, 1'b1, 1'b1, NONE);
        exp_frame(0, e + 120, 4, 1, 8'hA5, 32'hFEDCBA98, 1'b0, 1'b1, 1'b0, NONE);
        exp_frame(0, e + 160, 4, 1, 8'h00, 32'hFEDCBA98, 1'b0, 1'b1, 1'b0, e + 187);
        push_exp(0, e + 187, 3'd0, 3'b000, 4'h8, 1'b0, 1'b0);

        goto(e + 56);
        load0 = 1'b1; data0 = 32'hFEDCBA98;
        goto(e + 80);
        load0 = 1'b0;
        goto(e + 119);
        blank0 = 8'hA5;
        goto(e + 159);
        blank0 = 8'h00;
        goto(e + 186);
        en0 = 1'b0;

        // Re-enable restarts at digit 0, then reset lands mid-frame with a load pending
        goto(e + 195);
        en0 = 1'b1;
        e2 = cyc + 1;
        exp_frame(0, e2,      4, 1, 8'h00, 32'hFEDCBA98, 1'b1, 1'b0, 1'b0, NONE);
        exp_frame(0, e2 + 40, 4, 1, 8'h00, 32'hFEDCBA98, 1'b0, 1'b1, 1'b0, e2 + 52);
        goto(e2 + 42);
        load0 = 1'b1; data0 = 32'h11111111;
        goto(e2 + 52);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_x",   32'(x0),   32'd0);
        check("midrst_g",   32'(g0),   32'd0);
        check("midrst_hex", 32'(hex0), 32'd0);
        check("midrst_ack", 32'(ack0), 32'd0);
        check("midrst_fd",  32'(fd0),  32'd0);
        tick(); tick(); tick();
        load0 = 1'b0;
        en0   = 1'b0;
        rst_n = 1'b1;

        // DIV=2, GAP=3 instance: 40-cycle frame with three dark cycles per digit
        goto(cyc + 2);
        load1 = 1'b1; data1 = 32'h76543210;
        push_exp(1, cyc + 1, 3'd0, 3'b000, 4'h0, 1'b1, 1'b0);
        tick();
        load1 = 1'b0;
        goto(cyc + 2);
        en1 = 1'b1;
        e3 = cyc + 1;
        exp_frame(1, e3,      2, 3, 8'h00, 32'h76543210, 1'b1, 1'b0, 1'b0, NONE);
        exp_frame(1, e3 + 40, 2, 3, 8'h00, 32'h76543210, 1'b0, 1'b1, 1'b0, e3 + 41);
        push_exp(1, e3 + 41, 3'd0, 3'b000, 4'h0, 1'b0, 1'b0);
        goto(e3 + 40);
        en1 = 1'b0;

        goto(e3 + 60);
        check("drain_q0", 32'(q0.size()), 32'd0);
        check("drain_q1", 32'(q1.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
